// File: rtl/pad_sched_pkg.sv
// Shared state encoding and sizing helpers for the padded-stream scheduler.
package pad_sched_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t ISSUE = 2'd1;
   localparam state_t DRAIN = 2'd2;
   localparam state_t DONE  = 2'd3;

   // Index width that stays legal (>= 1 bit) for degenerate sizes such as N=1.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n < 2) ? 1 : int'($clog2(n));
   endfunction

   function automatic logic in_band(input int v, input int lo, input int hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO of scheduler beats with an occupancy count and a fall-through head.
// DEPTH must be a power of two so the pointers wrap naturally.
module stream_fifo #(
   parameter type         beat_t = logic [9:0],
   parameter int unsigned DEPTH  = 4,
   localparam int unsigned PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  beat_t            push_data,
   input  logic             pop,
   output beat_t            head,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   beat_t            mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/pad_stream_scheduler.sv
// Walks the zero-padded (N+2P)^2 grid row-major, reading each interior pixel once from BRAM
// and synthesizing border zeros, and emits an ordered valid/ready beat stream with markers.
module pad_stream_scheduler
   import pad_sched_pkg::*;
#(
   parameter int unsigned N          = 4,
   parameter int unsigned P          = 1,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   localparam int unsigned ADDR_W    = idx_width(N * N)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_rd_en,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_row_last,
   output logic                  m_last
);

   localparam int unsigned OUT_W = N + 2 * P;
   localparam int unsigned ROW_W = idx_width(OUT_W);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  row_last;
      logic                  last;
   } beat_t;

   state_t           state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [ROW_W-1:0] col_q, col_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   // Issue -> capture pipe stage; its valid bit is the single in-flight credit.
   logic pipe_valid_q;
   logic pipe_pad_q;
   logic pipe_row_last_q;
   logic pipe_last_q;

   logic             at_col_end;
   logic             at_row_end;
   logic             interior;
   logic             issue;
   logic             pop;
   logic [CNT_W:0]   occupancy;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_empty;
   beat_t            push_beat;
   beat_t            head_beat;

   assign at_col_end = (col_q == ROW_W'(OUT_W - 1));
   assign at_row_end = (row_q == ROW_W'(OUT_W - 1));
   assign interior   = in_band(int'(row_q), int'(P), int'(N + P)) &&
                       in_band(int'(col_q), int'(P), int'(N + P));

   // Counting this cycle's pop lets a depth-2 buffer sustain one beat per cycle.
   assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(pipe_valid_q) - (CNT_W + 1)'(pop);
   assign issue     = (state_q == ISSUE) && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
   assign pop       = m_valid && m_ready;

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      addr_d  = addr_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ISSUE;
               row_d   = '0;
               col_d   = '0;
               addr_d  = '0;
            end
         end
         ISSUE: begin
            if (issue) begin
               if (interior) begin
                  addr_d = addr_q + 1'b1;
               end
               if (at_col_end) begin
                  col_d = '0;
                  if (at_row_end) begin
                     row_d   = '0;
                     state_d = DRAIN;
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (pop && head_beat.last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q         <= IDLE;
         row_q           <= '0;
         col_q           <= '0;
         addr_q          <= '0;
         pipe_valid_q    <= 1'b0;
         pipe_pad_q      <= 1'b0;
         pipe_row_last_q <= 1'b0;
         pipe_last_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         row_q           <= row_d;
         col_q           <= col_d;
         addr_q          <= addr_d;
         pipe_valid_q    <= issue;
         pipe_pad_q      <= !interior;
         pipe_row_last_q <= at_col_end;
         pipe_last_q     <= at_col_end && at_row_end;
      end
   end

   always_comb begin
      push_beat.data     = pipe_pad_q ? '0 : mem_rd_data;
      push_beat.row_last = pipe_row_last_q;
      push_beat.last     = pipe_last_q;
   end

   stream_fifo #(
      .beat_t (beat_t),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (pipe_valid_q),
      .push_data (push_beat),
      .pop       (pop),
      .head      (head_beat),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign mem_rd_en  = issue && interior;
   assign mem_addr   = addr_q;
   assign m_valid    = !fifo_empty;
   // Head storage is not reset, so mask it while the buffer is empty.
   assign m_data     = fifo_empty ? '0 : head_beat.data;
   assign m_row_last = !fifo_empty && head_beat.row_last;
   assign m_last     = !fifo_empty && head_beat.last;

endmodule

// File: tb/tb_pad_stream_scheduler.sv
// Directed bench for pad_stream_scheduler: three configurations share clock and reset,
// one is exercised at a time through a selector.
module tb_pad_stream_scheduler;

   logic       clk     = 1'b0;
   logic       reset   = 1'b0;
   logic       m_ready = 1'b1;
   logic [2:0] start_v = '0;

   always #5 clk = ~clk;

   logic       busy_a, done_a, rd_en_a, valid_a, rl_a, last_a;
   logic [3:0] addr_a;
   logic [7:0] rd_data_a, data_a;
   logic       busy_b, done_b, rd_en_b, valid_b, rl_b, last_b;
   logic [3:0] addr_b;
   logic [7:0] rd_data_b, data_b;
   logic       busy_c, done_c, rd_en_c, valid_c, rl_c, last_c;
   logic [4:0] addr_c;
   logic [7:0] rd_data_c, data_c;

   pad_stream_scheduler #(.N(4), .P(1), .DATA_WIDTH(8), .FIFO_DEPTH(4)) u_a (
      .clk(clk), .reset(reset), .start(start_v[0]), .busy(busy_a), .done(done_a),
      .mem_rd_en(rd_en_a), .mem_addr(addr_a), .mem_rd_data(rd_data_a), .m_valid(valid_a),
      .m_ready(m_ready), .m_data(data_a), .m_row_last(rl_a), .m_last(last_a));

   pad_stream_scheduler #(.N(4), .P(0), .DATA_WIDTH(8), .FIFO_DEPTH(2)) u_b (
      .clk(clk), .reset(reset), .start(start_v[1]), .busy(busy_b), .done(done_b),
      .mem_rd_en(rd_en_b), .mem_addr(addr_b), .mem_rd_data(rd_data_b), .m_valid(valid_b),
      .m_ready(m_ready), .m_data(data_b), .m_row_last(rl_b), .m_last(last_b));

   pad_stream_scheduler #(.N(5), .P(2), .DATA_WIDTH(8), .FIFO_DEPTH(4)) u_c (
      .clk(clk), .reset(reset), .start(start_v[2]), .busy(busy_c), .done(done_c),
      .mem_rd_en(rd_en_c), .mem_addr(addr_c), .mem_rd_data(rd_data_c), .m_valid(valid_c),
      .m_ready(m_ready), .m_data(data_c), .m_row_last(rl_c), .m_last(last_c));

   // BRAM models: map[a] = a + 1, one-cycle read latency.
   always @(posedge clk) if (rd_en_a) rd_data_a <= 8'(addr_a) + 8'd1;
   always @(posedge clk) if (rd_en_b) rd_data_b <= 8'(addr_b) + 8'd1;
   always @(posedge clk) if (rd_en_c) rd_data_c <= 8'(addr_c) + 8'd1;

   int         sel = 0;
   logic       t_busy, t_done, t_rd_en, t_valid, t_rl, t_last;
   logic [7:0] t_addr, t_data;

   always_comb begin
      t_busy = busy_a; t_done = done_a; t_rd_en = rd_en_a; t_addr = 8'(addr_a);
      t_valid = valid_a; t_data = data_a; t_rl = rl_a; t_last = last_a;
      if (sel == 1) begin
         t_busy = busy_b; t_done = done_b; t_rd_en = rd_en_b; t_addr = 8'(addr_b);
         t_valid = valid_b; t_data = data_b; t_rl = rl_b; t_last = last_b;
      end else if (sel == 2) begin
         t_busy = busy_c; t_done = done_c; t_rd_en = rd_en_c; t_addr = 8'(addr_c);
         t_valid = valid_c; t_data = data_c; t_rl = rl_c; t_last = last_c;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [9:0] beat_q[$];
   int         beat_cyc_q[$];
   int         rd_q[$];
   int         done_cnt, done_cyc, stall_viol, deep_rd, stall_cycles, stall_run;
   logic       prev_stall;
   logic [9:0] prev_beat;

   always @(negedge clk) begin
      if (reset) begin
         if (t_valid && m_ready) begin
            beat_q.push_back({t_data, t_rl, t_last});
            beat_cyc_q.push_back(cyc);
         end
         if (t_rd_en) begin
            rd_q.push_back(int'(t_addr));
            // After four stalled cycles the credit window must be exhausted.
            if (!m_ready && stall_run >= 4) deep_rd <= deep_rd + 1;
         end
         if (t_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
         end
         if (prev_stall && (!t_valid || {t_data, t_rl, t_last} != prev_beat))
            stall_viol <= stall_viol + 1;
         if (t_valid && !m_ready) stall_cycles <= stall_cycles + 1;
         prev_stall <= t_valid && !m_ready;
         prev_beat  <= {t_data, t_rl, t_last};
         stall_run  <= m_ready ? 0 : stall_run + 1;
      end else begin
         prev_stall <= 1'b0;
         stall_run  <= 0;
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] exp_beat(input int n, input int p, input int idx);
      int         w, r, c;
      logic [7:0] v;
      w = n + 2 * p;
      r = idx / w;
      c = idx % w;
      if (r >= p && r < n + p && c >= p && c < n + p) v = 8'((r - p) * n + (c - p) + 1);
      else v = 8'd0;
      return {v, c == w - 1, (r == w - 1) && (c == w - 1)};
   endfunction

   task automatic clear_logs();
      beat_q.delete(); beat_cyc_q.delete(); rd_q.delete();
      done_cnt = 0; done_cyc = 0; stall_viol = 0; deep_rd = 0; stall_cycles = 0;
   endtask

   int start_cyc  = 0;
   int ready_mode = 0;
   bit pulse_start = 0;

   task automatic launch(input int s);
      sel = s;
      clear_logs();
      start_v[s] = 1'b1;
      @(posedge clk); #1;
      start_v[s] = 1'b0;
      start_cyc  = cyc;
   endtask

   // Entered at posedge+1; returns at the negedge of the done cycle (or on timeout).
   task automatic run_to_done(input int limit, output bit seen);
      int rel;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         rel = cyc - start_cyc;
         case (ready_mode)
            1:       m_ready = !((rel >= 3 && rel <= 12) || (rel >= 15 && rel <= 22));
            2:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b1;
         endcase
         if (pulse_start) start_v[sel] = (rel == 5) || (rel == 36);
         @(negedge clk);
         if (t_done) seen = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      start_v[sel] = 1'b0;
      m_ready      = 1'b1;
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
      @(negedge clk);
   endtask

   task automatic check_frame(input int n, input int p, input bit seen);
      int w2 = (n + 2 * p) * (n + 2 * p);
      check("done_seen", 32'(seen), 1);
      check("beat_count", beat_q.size(), w2);
      for (int i = 0; i < beat_q.size() && i < w2; i++)
         check($sformatf("beat%0d", i), 32'(beat_q[i]), 32'(exp_beat(n, p, i)));
      check("read_count", rd_q.size(), n * n);
      for (int i = 0; i < rd_q.size(); i++) check($sformatf("rd_addr%0d", i), rd_q[i], i);
      if (beat_cyc_q.size() > 0) check("done_after_last", done_cyc, beat_cyc_q[$] + 1);
      check("done_pulses", done_cnt, 1);
      check("stall_hold", stall_viol, 0);
      check("deep_stall_reads", deep_rd, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      int zeros;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      sel = 0;
      #1 check("reset_outputs_a", 32'({t_busy, t_done, t_rd_en, t_addr, t_valid, t_data,
                                       t_rl, t_last}), 0);
      sel = 2;
      #1 check("reset_outputs_c", 32'({t_busy, t_done, t_rd_en, t_addr, t_valid, t_data,
                                       t_rl, t_last}), 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("idle_busy", 32'(t_busy), 0);
      @(posedge clk); #1;

      // T1: N=4 P=1, ready held high
      launch(0);
      @(negedge clk);
      check("t1_rel0_valid", 32'(t_valid), 0);
      check("t1_rel0_busy", 32'(t_busy), 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("t1_rel1_valid", 32'(t_valid), 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("t1_rel2_valid", 32'(t_valid), 1);
      @(posedge clk); #1;
      run_to_done(100, seen);
      check("t1_done_busy", 32'(t_busy), 1);
      idle_cycle();
      check("t1_post_done", 32'({t_done, t_busy}), 0);
      check_frame(4, 1, seen);
      zeros = 0;
      foreach (beat_q[i]) if (beat_q[i][9:2] == 8'd0) zeros++;
      check("t1_zero_ring", zeros, 20);
      if (beat_q.size() == 36) begin
         check("t1_beat7", 32'(beat_q[7]), 32'({8'd1, 1'b0, 1'b0}));
         check("t1_beat28", 32'(beat_q[28]), 32'({8'd16, 1'b0, 1'b0}));
         check("t1_beat5", 32'(beat_q[5]), 32'({8'd0, 1'b1, 1'b0}));
         check("t1_beat35", 32'(beat_q[35]), 32'({8'd0, 1'b1, 1'b1}));
         check("t1_first_cyc", beat_cyc_q[0], start_cyc + 2);
         check("t1_last_cyc", beat_cyc_q[35], start_cyc + 37);
      end

      // T2: N=4 P=0, depth-2 buffer, pure passthrough at full rate
      idle_cycle();
      @(posedge clk); #1;
      launch(1);
      run_to_done(100, seen);
      idle_cycle();
      check_frame(4, 0, seen);
      if (beat_q.size() == 16) begin
         check("t2_beat3", 32'(beat_q[3]), 32'({8'd4, 1'b1, 1'b0}));
         check("t2_beat15", 32'(beat_q[15]), 32'({8'd16, 1'b1, 1'b1}));
         check("t2_rate", beat_cyc_q[15] - beat_cyc_q[0], 15);
      end

      // T3: T1 with two downstream stall windows
      idle_cycle();
      @(posedge clk); #1;
      ready_mode = 1;
      launch(0);
      run_to_done(100, seen);
      ready_mode = 0;
      idle_cycle();
      check_frame(4, 1, seen);
      check("t3_stalled_cycles", stall_cycles, 18);

      // T4: N=5 P=2 with random ready
      idle_cycle();
      @(posedge clk); #1;
      ready_mode = 2;
      launch(2);
      run_to_done(400, seen);
      ready_mode = 0;
      idle_cycle();
      check_frame(5, 2, seen);

      // T5: start pulsed in ISSUE, DRAIN and DONE must not spawn another frame
      idle_cycle();
      @(posedge clk); #1;
      pulse_start = 1'b1;
      launch(0);
      run_to_done(100, seen);
      pulse_start = 1'b0;
      start_v[0]  = 1'b1;
      @(posedge clk); #1;
      start_v[0]  = 1'b0;
      repeat (10) idle_cycle();
      check("t5_busy_after", 32'(t_busy), 0);
      check_frame(4, 1, seen);

      // T6: reset mid-frame, then a clean replay
      idle_cycle();
      @(posedge clk); #1;
      launch(0);
      for (int i = 0; i < 60 && beat_q.size() < 10; i++) begin
         @(negedge clk);
         if (beat_q.size() < 10) begin
            @(posedge clk); #1;
         end
      end
      check("t6_reached_beat10", beat_q.size(), 10);
      reset = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("t6_abort_outputs", 32'({t_busy, t_done, t_rd_en, t_addr, t_valid, t_data,
                                     t_rl, t_last}), 0);
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (6) idle_cycle();
      check("t6_no_more_beats", beat_q.size(), 10);
      check("t6_no_done", done_cnt, 0);
      check("t6_idle", 32'(t_busy), 0);
      @(posedge clk); #1;
      launch(0);
      run_to_done(100, seen);
      idle_cycle();
      check_frame(4, 1, seen);
      if (beat_cyc_q.size() == 36) check("t6_first_cyc", beat_cyc_q[0], start_cyc + 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
